// File: rtl/seven_seg_scanner.sv
// Multiplexed 7-segment display driver: synchronizes the divider's scan level,
// advances one digit per rising edge and renders a per-frame snapshot.
module seven_seg_scanner #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  neg,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     anode,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state, state_nxt;
  logic                s1, s2, s3;
  logic                tick;
  logic [IW-1:0]       idx, idx_nxt;
  logic [4*DIGITS-1:0] shadow, shadow_nxt;
  logic                neg_s, neg_nxt;
  logic                blank_s, blank_nxt;
  logic                load;
  logic                eff_neg;
  int                  k, p, pos;
  logic [3:0]          nib;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   anode_nxt;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  assign tick = s2 & ~s3;

  // The first tick out of idle and the tick on the last digit both start a frame.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    neg_nxt    = neg_s;
    blank_nxt  = blank_s;
    load       = 1'b0;
    if (tick) begin
      if (state == IDLE || idx == LAST) begin
        state_nxt  = SCAN;
        idx_nxt    = '0;
        shadow_nxt = value;
        neg_nxt    = neg;
        blank_nxt  = blank_lz;
        load       = 1'b1;
      end else begin
        idx_nxt = idx + 1'b1;
      end
    end
  end

  // Glyph for the digit about to be shown, taken from the post-tick snapshot.
  always_comb begin
    k = 0;
    for (int j = 0; j < DIGITS; j++) begin
      if (shadow_nxt[4*j +: 4] != 4'h0) k = j;
    end
    eff_neg = neg_nxt & (|shadow_nxt);
    if (blank_nxt && (k + 1 < DIGITS - 1)) p = k + 1;
    else                                   p = DIGITS - 1;
    pos       = int'(idx_nxt);
    nib       = shadow_nxt[4*pos +: 4];
    anode_nxt = ~(DIGITS'(1) << idx_nxt);
    if (eff_neg && pos == p)                glyph = 7'h3F;
    else if (blank_nxt && pos > k && pos > 0) glyph = 7'h7F;
    else                                    glyph = hex_glyph(nib);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      neg_s      <= 1'b0;
      blank_s    <= 1'b0;
      anode      <= '1;
      seg        <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      s1         <= scan_clk;
      s2         <= s1;
      s3         <= s2;
      state      <= state_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      neg_s      <= neg_nxt;
      blank_s    <= blank_nxt;
      frame_done <= load;
      if (tick) begin
        anode <= anode_nxt;
        seg   <= glyph;
      end
    end
  end

endmodule
